// File: rtl/rr_grant_encoder_if.sv
// Grant handshake bundle between requesters and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req high until served, owner pulses done to release.
//
// Signals:
//   req[7:0]        requester -> arbiter, level-sensitive request lines
//   done            requester -> arbiter, single-cycle release pulse from the owner
//   grant[7:0]      arbiter -> requester, registered one-hot grant
//   grant_idx[2:0]  arbiter -> requester, binary index of the grant (valid with grant_valid)
//   grant_valid     arbiter -> requester, high exactly when grant is non-zero
//   timeout         arbiter -> requester, one-cycle pulse after a forced release
interface rr_grant_encoder_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Requester side: drives requests and release, observes grant.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_encoder.sv
// Eight-way round-robin arbiter with held grants, a one-cycle turnaround gap and optional hold timeout.
// Latency: request sampled in IDLE -> grant visible the next cycle; release sampled in GRANT -> grant low the next cycle.
// Backpressure: none; a grant is held until done, request withdrawal, or (optional) forced timeout.
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   bus        rr_grant_encoder_if.slave: req/done in, grant/grant_idx/grant_valid/timeout out
// Parameters:
//   HOLD_MAX   maximum grant length in cycles (1..255), enforced only with timeout compiled in
// Build option:
//   RR_GRANT_TIMEOUT_EN  when defined, an 8-bit hold counter forces release after HOLD_MAX
//                        grant cycles and pulses timeout; when undefined, timeout is tied low.
module rr_grant_encoder #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_encoder_if.slave  bus
);

    // Reject out-of-range hold limits at elaboration rather than silently wrapping the counter.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_grant_encoder: HOLD_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t     state_q,   state_d;
    logic [2:0] ptr_q,     ptr_d;
    logic [7:0] grant_q,   grant_d;
    logic [2:0] idx_q,     idx_d;
    logic       valid_q,   valid_d;
    logic       timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    // Rotating the request vector so that bit 0 corresponds to ptr turns the
    // wrapping priority search into a plain lowest-set-bit search; the winner's
    // absolute index is then ptr plus the offset, wrapping naturally in 3 bits.
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  rot_off;
    logic [2:0]  pick_idx;
    logic        pick_vld;

    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[ptr_q +: 8];

    always_comb begin
        rot_off = 3'd0;
        // Scan downwards so the lowest set bit is the one left standing.
        for (int j = 7; j >= 0; j--) begin
            if (req_rot[j]) begin
                rot_off = 3'(j);
            end
        end
    end

    assign pick_idx = ptr_q + rot_off;
    assign pick_vld = |bus.req;

    // ------------------------------------------------------------------
    // Release conditions while in GRANT
    // ------------------------------------------------------------------
    logic owner_req;
    logic force_rel;
    logic rel_now;
    logic forced_only;

    assign owner_req = bus.req[idx_q];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    // Counts completed GRANT cycles minus one; zero on the first GRANT cycle,
    // so reaching HOLD_LAST means this is the HOLD_MAX-th cycle of the grant.
    logic [7:0] hold_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else if (state_q == ST_IDLE) begin
            hold_cnt_q <= 8'd0;
        end else if (state_q == ST_GRANT) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
        end
    end

    assign force_rel = (hold_cnt_q == HOLD_LAST);
`else
    assign force_rel = 1'b0;
`endif

    assign rel_now = bus.done || !owner_req || force_rel;

    // A timeout is only reported when the limit alone ends the grant; a
    // coincident done or withdrawal is an ordinary release.
    assign forced_only = force_rel && !bus.done && owner_req;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    grant_d = 8'd1 << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                end else begin
                    grant_d = 8'h00;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                // Other requesters are ignored here; only the owner's line,
                // done and the hold limit can end the grant.
                if (rel_now) begin
                    state_d   = ST_GAP;
                    ptr_d     = idx_q + 3'd1;
                    grant_d   = 8'h00;
                    idx_d     = 3'd0;
                    valid_d   = 1'b0;
                    timeout_d = forced_only;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 8'h00;
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            grant_q   <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Testbench for rr_grant_encoder: directed reset checks, then directed and random
// request/done patterns scored against a cycle-level reference model.
// Stimulus pushes expected outputs into a queue; a separate monitor pops and compares.
module tb_rr_grant_encoder;

    localparam int HOLD = 15;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_grant_encoder_if bus ();

    rr_grant_encoder #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: who owns the resource, how long, and whose turn is next.
    int m_ptr;
    int m_owner;
    int m_phase;   // 0 idle, 1 granted, 2 turnaround
    int m_held;    // grant cycles completed including the current one

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_phase = 0;
        m_held  = 0;
    endtask

    // Advance the model by one clock edge with inputs r/d and queue the outputs
    // expected to be visible after that edge.
    task automatic model_step(input logic [7:0] r, input logic d);
        exp_t e;
        e.grant = 8'h00;
        e.idx   = 3'd0;
        e.valid = 1'b0;
        e.to    = 1'b0;
        if (m_phase == 0) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_ptr + k) % 8] && m_phase == 0) begin
                        m_owner = (m_ptr + k) % 8;
                        m_phase = 1;
                        m_held  = 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            bit limit;
            limit = TO_EN && (m_held == HOLD);
            if (d || !r[m_owner] || limit) begin
                e.to    = limit && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_phase = 2;
            end else begin
                m_held++;
            end
        end else begin
            m_phase = 0;
        end
        if (m_phase == 1) begin
            e.grant = 8'd1 << m_owner;
            e.idx   = 3'(m_owner);
            e.valid = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] r, input logic d);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        model_step(r, d);
        mon_en = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
        chk({tag, "_idx"}, 32'(bus.grant_idx), 32'h0);
        chk({tag, "_valid"}, 32'(bus.grant_valid), 32'h0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", 32'(bus.grant), 32'(e.grant));
                    chk("grant_valid", 32'(bus.grant_valid), 32'(e.valid));
                    chk("timeout", 32'(bus.timeout), 32'(e.to));
                    if (e.valid) begin
                        chk("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic       d;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Grant requester 4, then reset asynchronously in the middle of the grant.
        @(negedge clk);
        bus.req = 8'h10;
        @(posedge clk);
        #2;
        chk("pre_reset_grant", 32'(bus.grant), 32'h10);
        chk("pre_reset_valid", 32'(bus.grant_valid), 32'h1);
        chk("pre_reset_idx", 32'(bus.grant_idx), 32'h4);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        bus.req = 8'h00;
        rst_n   = 1'b1;
        @(posedge clk);
        #2;
        chk_zero("post_reset_idle");
        model_reset();

        // Single requester 3, released by done in the 4th grant cycle, re-granted.
        repeat (3) begin
            repeat (4) drive(8'h08, 1'b0);
            drive(8'h08, 1'b1);
            drive(8'h08, 1'b0);
        end

        // Drain to IDLE, then all requesting with done every grant cycle.
        repeat (3) drive(8'h00, 1'b0);
        repeat (30) drive(8'hFF, 1'b1);

        // Wrap-around: grant 7, release, then 7 and 0 both request.
        repeat (3) drive(8'h00, 1'b0);
        drive(8'h80, 1'b0);
        drive(8'h80, 1'b1);
        drive(8'h81, 1'b0);
        drive(8'h81, 1'b0);
        drive(8'h81, 1'b0);
        drive(8'h81, 1'b1);

        // Withdrawal: 2 and 5 request, 2 drops its line without done.
        repeat (3) drive(8'h00, 1'b0);
        repeat (3) drive(8'h24, 1'b0);
        repeat (3) drive(8'h20, 1'b0);
        drive(8'h20, 1'b1);

        // Long hold without done: timeout build releases every HOLD cycles.
        repeat (3) drive(8'h00, 1'b0);
        repeat (120) drive(8'h02, 1'b0);

        // Random traffic: slowly changing requests, occasional done.
        r = 8'h00;
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) begin
                r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            d = ($urandom_range(0, 4) == 0);
            drive(r, d);
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
